// File: rtl/wishbone_master_if.sv
// Client request/response and Wishbone classic bus signals of wishbone_master.
// The master modport is the engine's view; the slave modport is the client/bus side.
interface wishbone_master_if;
  logic        req_i;
  logic        req_we_i;
  logic [15:0] req_adr_i;
  logic [3:0]  req_len_i;
  logic [7:0]  req_dat_i;
  logic        busy_o;
  logic        beat_o;
  logic [3:0]  beat_cnt_o;
  logic [7:0]  rd_dat_o;
  logic        done_o;
  logic        err_o;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [15:0] adr_o;
  logic [7:0]  dat_o;
  logic [7:0]  dat_i;
  logic        ack_i;

  modport master (
    input  req_i, req_we_i, req_adr_i, req_len_i, req_dat_i, dat_i, ack_i,
    output busy_o, beat_o, beat_cnt_o, rd_dat_o, done_o, err_o,
           cyc_o, stb_o, we_o, adr_o, dat_o
  );

  modport slave (
    output req_i, req_we_i, req_adr_i, req_len_i, req_dat_i, dat_i, ack_i,
    input  busy_o, beat_o, beat_cnt_o, rd_dat_o, done_o, err_o,
           cyc_o, stb_o, we_o, adr_o, dat_o
  );
endinterface

// File: rtl/wishbone_master.sv
// Wishbone classic burst master: 1-16 sequential byte beats with incrementing
// address, one-cycle gap between beats, and a per-beat acknowledge timeout.
module wishbone_master #(
  parameter int TIMEOUT = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  wishbone_master_if.master bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t          state_r,    state_nxt_s;
  logic            we_r,       we_nxt_s;
  logic [3:0]      len_r,      len_nxt_s;
  logic [3:0]      cnt_r,      cnt_nxt_s;
  logic [TW-1:0]   tmo_r,      tmo_nxt_s;
  logic [15:0]     adr_r,      adr_nxt_s;
  logic [7:0]      dat_r,      dat_nxt_s;
  logic [7:0]      rd_dat_r,   rd_dat_nxt_s;
  logic            beat_r,     beat_nxt_s;
  logic            done_r,     done_nxt_s;
  logic            err_r,      err_nxt_s;
  logic            ack_s;

  // Floating or unknown acknowledge from an undecoded slave is not an acknowledge.
  assign ack_s = (bus.ack_i === 1'b1);

  // Next-state and next-register logic for the beat sequencer.
  always_comb begin
    state_nxt_s  = state_r;
    we_nxt_s     = we_r;
    len_nxt_s    = len_r;
    cnt_nxt_s    = cnt_r;
    tmo_nxt_s    = tmo_r;
    adr_nxt_s    = adr_r;
    dat_nxt_s    = dat_r;
    rd_dat_nxt_s = rd_dat_r;
    beat_nxt_s   = 1'b0;
    done_nxt_s   = 1'b0;
    err_nxt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req_i) begin
          state_nxt_s = ACTIVE;
          we_nxt_s    = bus.req_we_i;
          adr_nxt_s   = bus.req_adr_i;
          len_nxt_s   = bus.req_len_i;
          dat_nxt_s   = bus.req_dat_i;
          cnt_nxt_s   = 4'd0;
          tmo_nxt_s   = {TW{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACTIVE: begin
        if (ack_s) begin
          beat_nxt_s = 1'b1;
          tmo_nxt_s  = {TW{1'b0}};
          if (!we_r) begin
            rd_dat_nxt_s = bus.dat_i;
          end else begin
            rd_dat_nxt_s = rd_dat_r;
          end
          // Count returns to 0 so an idle client sees beat 0 as the next index.
          if (cnt_r == len_r) begin
            state_nxt_s = IDLE;
            done_nxt_s  = 1'b1;
            cnt_nxt_s   = 4'd0;
          end else begin
            state_nxt_s = GAP;
            cnt_nxt_s   = cnt_r + 4'd1;
            adr_nxt_s   = adr_r + 16'd1;
          end
        end else if (tmo_r == TW'(TIMEOUT - 1)) begin
          state_nxt_s = IDLE;
          err_nxt_s   = 1'b1;
          cnt_nxt_s   = 4'd0;
        end else begin
          tmo_nxt_s = tmo_r + TW'(1);
        end
      end
      GAP: begin
        state_nxt_s = ACTIVE;
        dat_nxt_s   = bus.req_dat_i;
        tmo_nxt_s   = {TW{1'b0}};
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_r     <= 1'b0;
      len_r    <= 4'd0;
      cnt_r    <= 4'd0;
      tmo_r    <= {TW{1'b0}};
      adr_r    <= 16'h0000;
      dat_r    <= 8'h00;
      rd_dat_r <= 8'h00;
      beat_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      we_r     <= we_nxt_s;
      len_r    <= len_nxt_s;
      cnt_r    <= cnt_nxt_s;
      tmo_r    <= tmo_nxt_s;
      adr_r    <= adr_nxt_s;
      dat_r    <= dat_nxt_s;
      rd_dat_r <= rd_dat_nxt_s;
      beat_r   <= beat_nxt_s;
      done_r   <= done_nxt_s;
      err_r    <= err_nxt_s;
    end
  end

  assign bus.busy_o     = (state_r != IDLE);
  assign bus.cyc_o      = (state_r != IDLE);
  assign bus.stb_o      = (state_r == ACTIVE);
  assign bus.we_o       = we_r;
  assign bus.adr_o      = adr_r;
  assign bus.dat_o      = dat_r;
  assign bus.rd_dat_o   = rd_dat_r;
  assign bus.beat_o     = beat_r;
  assign bus.beat_cnt_o = cnt_r;
  assign bus.done_o     = done_r;
  assign bus.err_o      = err_r;
endmodule

// File: tb/tb_wishbone_master.sv
// Directed bench for wishbone_master: memory-backed slave model decoding address
// nibbles 0x0 and 0xF, with an optional wait-state count before acknowledge.
module tb_wishbone_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wishbone_master_if bus();

  wishbone_master #(.TIMEOUT(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [7:0]  mem [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_adr = 16'h0000;
  logic [7:0]  pl_dat = 8'h00;
  int          wait_n = 0;
  int          wcnt = 0;
  logic        wr_burst = 1'b0;
  logic [7:0]  fixed_dat = 8'h00;
  logic        dec_s;

  assign dec_s         = (bus.adr_o[15:12] == 4'h0) || (bus.adr_o[15:12] == 4'hF);
  assign bus.ack_i     = bus.stb_o && dec_s && (wcnt == wait_n);
  assign bus.dat_i     = mem[bus.adr_o];
  assign bus.req_dat_i = wr_burst ? (8'h10 + {4'h0, bus.beat_cnt_o}) : fixed_dat;

  // Slave memory write port and bench preload port.
  always @(posedge clk) begin
    if (bus.stb_o && bus.ack_i && bus.we_o) mem[bus.adr_o] <= bus.dat_o;
    else if (pl_en) mem[pl_adr] <= pl_dat;
    wcnt <= (bus.stb_o && !bus.ack_i) ? wcnt + 1 : 0;
  end

  // Bus observer.
  int cyc_n = 0, n_done = 0, n_err = 0, n_cyc = 0, n_stb = 0;
  int t_done = 0, t_err = 0, t_ack = 0, t_stb = 0;
  logic [15:0] ack_adr_q[$];
  logic [7:0]  rd_q[$];
  int          beat_t_q[$];
  always @(negedge clk) begin
    cyc_n <= cyc_n + 1;
    if (bus.cyc_o) n_cyc <= n_cyc + 1;
    if (bus.stb_o) begin
      n_stb <= n_stb + 1;
      t_stb <= cyc_n;
    end
    if (bus.stb_o && bus.ack_i) begin
      ack_adr_q.push_back(bus.adr_o);
      t_ack <= cyc_n;
    end
    if (bus.beat_o) begin
      beat_t_q.push_back(cyc_n);
      if (!bus.we_o) rd_q.push_back(bus.rd_dat_o);
    end
    if (bus.done_o) begin
      n_done <= n_done + 1;
      t_done <= cyc_n;
    end
    if (bus.err_o) begin
      n_err <= n_err + 1;
      t_err <= cyc_n;
    end
  end

  int n_cmp = 0, n_bad = 0;
  int b_done, b_err, b_cyc, b_stb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_adr = a; pl_dat = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic start(input logic we, input logic [15:0] a, input logic [3:0] len);
    @(negedge clk);
    ack_adr_q.delete(); rd_q.delete(); beat_t_q.delete();
    b_done = n_done; b_err = n_err; b_cyc = n_cyc; b_stb = n_stb;
    bus.req_i = 1'b1; bus.req_we_i = we; bus.req_adr_i = a; bus.req_len_i = len;
    @(negedge clk);
    bus.req_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (!bus.busy_o) break;
      @(negedge clk);
    end
    check({tag, "_idle_bound"}, {31'd0, bus.busy_o}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    bus.req_i = 1'b0; bus.req_we_i = 1'b0; bus.req_adr_i = 16'h0000; bus.req_len_i = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {25'd0, bus.busy_o, bus.beat_o, bus.done_o, bus.err_o, bus.cyc_o, bus.stb_o, bus.we_o}, 32'd0);
    check("rst_adr_dat", {bus.adr_o, bus.dat_o, bus.rd_dat_o}, 32'd0);
    check("rst_beat_cnt", {28'd0, bus.beat_cnt_o}, 32'd0);
    rst = 1'b0;

    preload(16'h0FFE, 8'h11); preload(16'h0FFF, 8'h22);
    preload(16'h1000, 8'h33); preload(16'h1001, 8'h44);
    preload(16'hFFFF, 8'h5A); preload(16'h0000, 8'hC3);
    preload(16'h0300, 8'h77); preload(16'h0301, 8'h88);

    // Single write, then read it back through the engine.
    fixed_dat = 8'hA5;
    start(1'b1, 16'h0123, 4'd0);
    wait_idle("wr1");
    check("wr1_stb", n_stb - b_stb, 32'd1);
    check("wr1_cyc", n_cyc - b_cyc, 32'd1);
    check("wr1_adr", {16'd0, ack_adr_q[0]}, 32'h0123);
    check("wr1_done", n_done - b_done, 32'd1);
    check("wr1_done_lat", t_done - t_ack, 32'd1);
    check("wr1_mem", {24'd0, mem[16'h0123]}, 32'hA5);
    start(1'b0, 16'h0123, 4'd0);
    wait_idle("rb1");
    check("rb1_data", {24'd0, rd_q[0]}, 32'hA5);

    // Burst read crossing into an undecoded region: times out on the third beat.
    start(1'b0, 16'h0FFE, 4'd3);
    wait_idle("to");
    check("to_acks", ack_adr_q.size(), 32'd2);
    check("to_adr0", {16'd0, ack_adr_q[0]}, 32'h0FFE);
    check("to_adr1", {16'd0, ack_adr_q[1]}, 32'h0FFF);
    check("to_rd0", {24'd0, rd_q[0]}, 32'h11);
    check("to_rd1", {24'd0, rd_q[1]}, 32'h22);
    check("to_stb", n_stb - b_stb, 32'd18);
    check("to_err", n_err - b_err, 32'd1);
    check("to_err_lat", t_err - t_stb, 32'd1);
    check("to_done", n_done - b_done, 32'd0);
    check("to_beats", beat_t_q.size(), 32'd2);

    // Burst write, data from beat index.
    wr_burst = 1'b1;
    start(1'b1, 16'h0200, 4'd3);
    wait_idle("bw");
    wr_burst = 1'b0;
    for (int i = 0; i < 4; i++) check("bw_mem", {24'd0, mem[16'h0200 + 16'(i)]}, 32'h10 + 32'(i));
    check("bw_beats", beat_t_q.size(), 32'd4);
    for (int i = 0; i < 3; i++) check("bw_spacing", beat_t_q[i+1] - beat_t_q[i], 32'd2);
    check("bw_cyc", n_cyc - b_cyc, 32'd7);
    check("bw_done", n_done - b_done, 32'd1);

    // Address wrap.
    start(1'b0, 16'hFFFF, 4'd1);
    wait_idle("wrap");
    check("wrap_adr0", {16'd0, ack_adr_q[0]}, 32'hFFFF);
    check("wrap_adr1", {16'd0, ack_adr_q[1]}, 32'h0000);
    check("wrap_rd", {16'd0, rd_q[0], rd_q[1]}, 32'h5AC3);
    check("wrap_done", n_done - b_done, 32'd1);

    // Acknowledge in the last permitted cycle beats the timeout.
    wait_n = 15;
    start(1'b0, 16'h0123, 4'd0);
    wait_idle("late");
    wait_n = 0;
    check("late_stb", n_stb - b_stb, 32'd16);
    check("late_done", n_done - b_done, 32'd1);
    check("late_err", n_err - b_err, 32'd0);
    check("late_rd", {24'd0, rd_q[0]}, 32'hA5);

    // Asynchronous reset during the second beat.
    start(1'b0, 16'h0300, 4'd3);
    for (int i = 0; i < 20; i++) begin
      if (bus.stb_o && bus.beat_cnt_o == 4'd1) break;
      @(negedge clk);
    end
    check("rst_mid_reached", {31'd0, bus.stb_o}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_bus", {29'd0, bus.cyc_o, bus.stb_o, bus.busy_o}, 32'd0);
    check("rst_mid_cnt", {28'd0, bus.beat_cnt_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start(1'b0, 16'h0300, 4'd0);
    wait_idle("rst_new");
    check("rst_new_adr", {16'd0, ack_adr_q[0]}, 32'h0300);
    check("rst_new_rd", {24'd0, rd_q[0]}, 32'h77);

    // Second request while busy is ignored.
    start(1'b0, 16'h0400, 4'd3);
    @(negedge clk);
    bus.req_i = 1'b1; bus.req_adr_i = 16'h0F00; bus.req_len_i = 4'd0;
    @(negedge clk);
    bus.req_i = 1'b0;
    wait_idle("busy");
    repeat (5) @(negedge clk);
    check("busy_acks", ack_adr_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) check("busy_adr", {16'd0, ack_adr_q[i]}, 32'h0400 + 32'(i));
    check("busy_done", n_done - b_done, 32'd1);
    check("busy_cyc", n_cyc - b_cyc, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
